// File: rtl/ex_mul_issue_if.sv
// Issue/collect bus between ID/EX, the multiplier and EX/MEM.
interface ex_mul_issue_if #(
  parameter int unsigned OP_W = 8
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_is_mul;
  logic [OP_W-1:0] in_op;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic [31:0]     in_alu_res;
  logic [4:0]      in_dest;
  logic [31:0]     in_pc;
  logic [OP_W-1:0] mul_op;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_done;
  logic [31:0]     mul_res;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_res;
  logic [4:0]      out_dest;
  logic [31:0]     out_pc;
  logic            out_err;
  logic            busy;

  // Controller side
  modport slave (
    input  flush, in_valid, in_is_mul, in_op, in_a, in_b, in_alu_res, in_dest, in_pc,
    input  mul_done, mul_res, out_ready,
    output in_ready, mul_op, mul_a, mul_b, out_valid, out_res, out_dest, out_pc, out_err, busy
  );

  // Environment side (ID/EX, multiplier, EX/MEM)
  modport master (
    output flush, in_valid, in_is_mul, in_op, in_a, in_b, in_alu_res, in_dest, in_pc,
    output mul_done, mul_res, out_ready,
    input  in_ready, mul_op, mul_a, mul_b, out_valid, out_res, out_dest, out_pc, out_err, busy
  );
endinterface

// File: rtl/ex_mul_issue.sv
// EX-stage issue/collect controller in front of the multiplier unit.
// One instruction in flight; multiply ops wait for the unit's done pulse,
// other ops pass their ALU result straight to the output stage.
module ex_mul_issue #(
  parameter int unsigned LAT     = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned OP_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_mul_issue_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [4:0]       r_dest;
  logic [31:0]      r_pc;
  logic [31:0]      r_res;
  logic             r_err;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;

  // Handshake and status decode from the state register
  assign bus.in_ready  = rst_n & (r_state == S_IDLE) & ~bus.flush;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign bus.mul_op    = (r_state == S_BUSY) ? r_op : '0;
  assign bus.mul_a     = r_a;
  assign bus.mul_b     = r_b;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_res   = r_res;
  assign bus.out_dest  = r_dest;
  assign bus.out_pc    = r_pc;
  assign bus.out_err   = r_err;
  assign bus.busy      = (r_state != S_IDLE);

  // Controller FSM with operand/result capture; flush outranks every other event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_dest  <= '0;
      r_pc    <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.in_op;
            r_a    <= bus.in_a;
            r_b    <= bus.in_b;
            r_dest <= bus.in_dest;
            r_pc   <= bus.in_pc;
            r_cnt  <= '0;
            if (bus.in_is_mul) begin
              r_state <= S_BUSY;
            end else begin
              r_res   <= bus.in_alu_res;
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else if (bus.mul_done) begin
            r_res   <= bus.mul_res;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        // Wait out the unit's pipeline so its stale done pulse cannot alias a new op
        S_DRAIN: begin
          if (r_cnt == CNT_W'(LAT)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          if (bus.flush || bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_issue.sv
// Directed bench for ex_mul_issue with a behavioural multiplier and a result scoreboard.
module tb_ex_mul_issue;

  localparam int unsigned LAT     = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned OP_W    = 8;

  localparam logic [OP_W-1:0] OP_MUL   = 8'h01;
  localparam logic [OP_W-1:0] OP_MULH  = 8'h02;
  localparam logic [OP_W-1:0] OP_MULHU = 8'h03;
  localparam logic [OP_W-1:0] OP_ADD   = 8'h10;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ex_mul_issue_if #(.OP_W(OP_W)) bus ();

  ex_mul_issue #(.LAT(LAT), .TIMEOUT(TIMEOUT), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural multiplier: samples a nonzero op, pulses done LAT cycles later
  logic            m_active;
  int              m_cnt;
  logic            m_hang;
  logic [OP_W-1:0] m_op;
  logic [31:0]     m_a;
  logic [31:0]     m_b;

  function automatic logic [31:0] mul_func(input logic [OP_W-1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] ps;
    pu = {32'd0, a} * {32'd0, b};
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      OP_MULH:  return ps[63:32];
      OP_MULHU: return pu[63:32];
      default:  return pu[31:0];
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (m_active) begin
      if (m_cnt == int'(LAT)) m_active <= 1'b0;
      else                    m_cnt    <= m_cnt + 1;
    end else if (bus.mul_op != '0) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      m_op     <= bus.mul_op;
      m_a      <= bus.mul_a;
      m_b      <= bus.mul_b;
    end
  end

  assign bus.mul_done = m_active && (m_cnt == int'(LAT)) && !m_hang;
  assign bus.mul_res  = m_active ? mul_func(m_op, m_a, m_b) : 32'h0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=output expected=empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_res"},  bus.out_res,           e.res);
      chk({tag, "_dest"}, 32'(bus.out_dest),     32'(e.dest));
      chk({tag, "_pc"},   bus.out_pc,            e.pc);
      chk({tag, "_err"},  32'(bus.out_err),      32'(e.err));
    end
  endtask

  task automatic wait_out(input string tag, input int max_cyc);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (bus.out_valid === 1'b1) compare_out(tag);
  endtask

  // Present one entry in the current cycle; returns in the following cycle
  task automatic issue(input string tag, input logic is_mul, input logic [OP_W-1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                       input logic [4:0] dest, input logic [31:0] pc);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_is_mul  = is_mul;
    bus.in_op      = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_alu_res = alu;
    bus.in_dest    = dest;
    bus.in_pc      = pc;
    step();
    bus.in_valid   = 1'b0;
  endtask

  task automatic drain_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_mul_op"},    32'(bus.mul_op),    32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    chk({tag, "_out_res"},   bus.out_res,        32'd0);
    chk({tag, "_out_dest"},  32'(bus.out_dest),  32'd0);
    chk({tag, "_mul_a"},     bus.mul_a,          32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    m_hang         = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_is_mul  = 1'b0;
    bus.in_op      = '0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_alu_res = '0;
    bus.in_dest    = '0;
    bus.in_pc      = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (3) step();
    chk_cleared("reset");
    rst_n = 1'b1;
    #1;
    chk("reset_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // 1: MUL 3 * 0xFFFFFFFE, done in cycle 3, output in cycle 4
    exp_q.push_back('{32'hFFFF_FFFA, 5'd3, 32'h0000_0100, 1'b0});
    issue("mul1", 1'b1, OP_MUL, 32'h0000_0003, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 5'd3, 32'h0000_0100);
    chk("mul1_c1_mul_op",    32'(bus.mul_op),    32'(OP_MUL));
    chk("mul1_c1_mul_a",     bus.mul_a,          32'h0000_0003);
    chk("mul1_c1_mul_b",     bus.mul_b,          32'hFFFF_FFFE);
    chk("mul1_c1_busy",      32'(bus.busy),      32'd1);
    chk("mul1_c1_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    chk("mul1_c2_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("mul1_c3_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mul1_c3_mul_op",    32'(bus.mul_op),    32'(OP_MUL));
    step();
    chk("mul1_c4_out_valid", 32'(bus.out_valid), 32'd1);
    chk("mul1_c4_mul_op",    32'(bus.mul_op),    32'd0);
    compare_out("mul1");
    drain_out();
    chk("mul1_c5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mul1_c5_in_ready",  32'(bus.in_ready),  32'd1);

    // 2: non-mul pass-through, output in cycle 1
    exp_q.push_back('{32'h1234_5678, 5'd5, 32'h1C00_0010, 1'b0});
    chk("alu_c0_mul_op", 32'(bus.mul_op), 32'd0);
    issue("alu", 1'b0, OP_ADD, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 5'd5, 32'h1C00_0010);
    chk("alu_c1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("alu_c1_mul_op",    32'(bus.mul_op),    32'd0);
    compare_out("alu");
    drain_out();
    chk("alu_c2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("alu_c2_mul_op",    32'(bus.mul_op),    32'd0);

    // 3: MULHU held by out_ready low for 5 cycles, then back-to-back accept
    exp_q.push_back('{32'hFFFF_FFFE, 5'd7, 32'h0000_0200, 1'b0});
    issue("mulhu", 1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd7, 32'h0000_0200);
    repeat (3) step();
    chk("mulhu_c4_out_valid", 32'(bus.out_valid), 32'd1);
    compare_out("mulhu");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mulhu_hold%0d_valid", i),    32'(bus.out_valid), 32'd1);
      chk($sformatf("mulhu_hold%0d_res", i),      bus.out_res,        32'hFFFF_FFFE);
      chk($sformatf("mulhu_hold%0d_dest", i),     32'(bus.out_dest),  32'd7);
      chk($sformatf("mulhu_hold%0d_in_ready", i), 32'(bus.in_ready),  32'd0);
      step();
    end
    drain_out();
    chk("mulhu_idle_busy",     32'(bus.busy),     32'd0);
    chk("mulhu_idle_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back('{32'h0BAD_F00D, 5'd9, 32'h0000_0300, 1'b0});
    issue("b2b", 1'b0, OP_ADD, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd9, 32'h0000_0300);
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    compare_out("b2b");
    drain_out();

    // 4: flush in cycle 2 of a MUL, drain for LAT+1 cycles, late done ignored
    issue("flush", 1'b1, OP_MUL, 32'h0000_0005, 32'h0000_0006, 32'h0, 5'd1, 32'h0000_0400);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain%0d_busy", i),      32'(bus.busy),      32'd1);
      chk($sformatf("drain%0d_in_ready", i),  32'(bus.in_ready),  32'd0);
      chk($sformatf("drain%0d_mul_op", i),    32'(bus.mul_op),    32'd0);
      chk($sformatf("drain%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
      bus.flush = (i == 1);
      step();
      bus.flush = 1'b0;
    end
    #1;
    chk("drain_end_busy",      32'(bus.busy),      32'd0);
    chk("drain_end_in_ready",  32'(bus.in_ready),  32'd1);
    chk("drain_end_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // 5: unit never answers, watchdog exits after TIMEOUT busy cycles
    m_hang = 1'b1;
    exp_q.push_back('{32'h0, 5'd2, 32'h0000_0500, 1'b1});
    issue("wd", 1'b1, OP_MUL, 32'h0000_0007, 32'h0000_0008, 32'h0, 5'd2, 32'h0000_0500);
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      chk($sformatf("wd_c%0d_out_valid", c), 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("wd_out_valid", 32'(bus.out_valid), 32'd1);
    chk("wd_mul_op",    32'(bus.mul_op),    32'd0);
    compare_out("wd");
    drain_out();
    m_hang = 1'b0;
    step();

    // 6a: reset while BUSY
    issue("rstb", 1'b1, OP_MUL, 32'h0000_0009, 32'h0000_0009, 32'h0, 5'd4, 32'h0000_0600);
    chk("rstb_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk_cleared("rstb");
    rst_n = 1'b1;
    #1;
    chk("rstb_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // 6b: reset while DONE
    exp_q.push_back('{32'hCAFE_0001, 5'd6, 32'h0000_0700, 1'b0});
    issue("rstd", 1'b0, OP_ADD, 32'h0, 32'h0, 32'hCAFE_0001, 5'd6, 32'h0000_0700);
    chk("rstd_out_valid", 32'(bus.out_valid), 32'd1);
    compare_out("rstd");
    rst_n = 1'b0;
    step();
    chk_cleared("rstd");
    chk("rstd_out_pc", bus.out_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rstd_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // 6c: MULH after reset completes normally
    exp_q.push_back('{32'hFFFF_FFFF, 5'd8, 32'h0000_0800, 1'b0});
    issue("mulh", 1'b1, OP_MULH, 32'h8000_0000, 32'h0000_0002, 32'h0, 5'd8, 32'h0000_0800);
    wait_out("mulh", 10);
    drain_out();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
